// File: rtl/eq_sched_pkg.sv
// rtl/eq_sched_pkg.sv - shared types and helpers for the channel frame scheduler
package eq_sched_pkg;

   typedef enum logic {
      WAIT_ALL = 1'b0,
      ISSUE    = 1'b1
   } sched_state_t;

   localparam int STAT_W = 16;

   function automatic int ch_w(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_sched_oreg.sv
// rtl/fifo_sched_oreg.sv - valid/ready output register feeding the shared datapath
module fifo_sched_oreg #(
   parameter int D_WIDTH = 24,
   parameter int CH_W    = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               push_i,
   input  logic [D_WIDTH-1:0] data_i,
   input  logic [CH_W-1:0]    chan_i,
   input  logic               sof_i,
   input  logic               ready_i,
   output logic [D_WIDTH-1:0] data_o,
   output logic [CH_W-1:0]    chan_o,
   output logic               sof_o,
   output logic               valid_o,
   output logic               load_o
);

   logic [D_WIDTH-1:0] data_q, data_d;
   logic [CH_W-1:0]    chan_q, chan_d;
   logic               sof_q, sof_d;
   logic               valid_q, valid_d;

   // Register can take a new word when empty or when its current word leaves this cycle
   assign load_o = ~valid_q | ready_i;

   always_comb begin
      data_d  = data_q;
      chan_d  = chan_q;
      sof_d   = sof_q;
      valid_d = valid_q;
      if (push_i) begin
         data_d  = data_i;
         chan_d  = chan_i;
         sof_d   = sof_i;
         valid_d = 1'b1;
      end else if (ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q  <= '0;
         chan_q  <= '0;
         sof_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         chan_q  <= chan_d;
         sof_q   <= sof_d;
         valid_q <= valid_d;
      end
   end

   assign data_o  = data_q;
   assign chan_o  = chan_q;
   assign sof_o   = sof_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/fifo_frame_scheduler.sv
// rtl/fifo_frame_scheduler.sv - sample-aligned frame reader over N channel FIFOs
// Optional FIFO_FRAME_SCHED_STATS_EN adds frame and stall counters.
module fifo_frame_scheduler
   import eq_sched_pkg::*;
#(
   parameter int N_CH    = 2,
   parameter int D_WIDTH = 24,
   localparam int CH_W   = ch_w(N_CH)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [N_CH*D_WIDTH-1:0] data_i,
   input  logic [N_CH-1:0]         empty_i,
   input  logic [N_CH-1:0]         full_i,
   output logic [N_CH-1:0]         rdreq_o,
   output logic [D_WIDTH-1:0]      data_o,
   output logic [CH_W-1:0]         chan_o,
   output logic                    sof_o,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic                    desync_o,
`ifdef FIFO_FRAME_SCHED_STATS_EN
   output logic [STAT_W-1:0]       frame_cnt_o,
   output logic [STAT_W-1:0]       stall_cnt_o,
`endif
   input  logic                    desync_clr_i
);

   sched_state_t       state_q, state_d;
   logic [CH_W-1:0]    ptr_q, ptr_d;
   logic               desync_q, desync_d;
   logic               load;
   logic               push;
   logic               last_ch;
   logic [D_WIDTH-1:0] head_word;

   assign push    = (state_q == ISSUE) & load;
   assign last_ch = (ptr_q == CH_W'(N_CH - 1));

   always_comb begin
      head_word = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (ptr_q == CH_W'(k)) head_word = data_i[k*D_WIDTH +: D_WIDTH];
      end
   end

   // Pop strobe must never leak during reset, otherwise a reset frame would lose a word
   always_comb begin
      rdreq_o = '0;
      for (int k = 0; k < N_CH; k++) begin
         rdreq_o[k] = push & ~rst_i & (ptr_q == CH_W'(k));
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      desync_d = desync_q;
      case (state_q)
         WAIT_ALL: begin
            if ((empty_i == '0) && load) begin
               state_d = ISSUE;
               ptr_d   = '0;
            end
         end
         ISSUE: begin
            if (load) begin
               if (last_ch) begin
                  state_d = WAIT_ALL;
                  ptr_d   = '0;
               end else begin
                  ptr_d = ptr_q + CH_W'(1);
               end
            end
         end
         default: state_d = WAIT_ALL;
      endcase
      if (desync_clr_i) desync_d = 1'b0;
      if ((state_q == WAIT_ALL) && ((full_i & ~empty_i) != '0) && (empty_i != '0)) desync_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= WAIT_ALL;
         ptr_q    <= '0;
         desync_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         desync_q <= desync_d;
      end
   end

   assign desync_o = desync_q;

   fifo_sched_oreg #(
      .D_WIDTH (D_WIDTH),
      .CH_W    (CH_W)
   ) u_oreg (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .data_i  (head_word),
      .chan_i  (ptr_q),
      .sof_i   (ptr_q == '0),
      .ready_i (ready_i),
      .data_o  (data_o),
      .chan_o  (chan_o),
      .sof_o   (sof_o),
      .valid_o (valid_o),
      .load_o  (load)
   );

`ifdef FIFO_FRAME_SCHED_STATS_EN
   logic [STAT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (valid_o && ready_i && (chan_o == CH_W'(N_CH - 1))) frame_cnt_d = frame_cnt_q + STAT_W'(1);
      if (valid_o && !ready_i && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + STAT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         frame_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign frame_cnt_o = frame_cnt_q;
   assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
